// File: rtl/kernel_window_gen.sv
// ----------------------------------------------------------------------------
// kernel_window_gen
//   Builds a 7x7 pixel neighbourhood from a raster-order pixel stream for the
//   downstream 7x7 kernel multiply stage. Six line buffers hold the previous
//   six rows. A 7x7 register window shifts in one fresh column per accepted
//   pixel. A window is presented only when all 49 taps belong to the current
//   frame and to real (non-wrapped) columns.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   pixel_in     : input pixel (raw bit pattern, passed through untouched)
//   pixel_valid  : pixel_in qualifier, always accepted (no backpressure)
//   kernel       : 7x7 window, element r*7+c = row r, column c, row 0 on top
//   kernel_valid : one-cycle qualifier for kernel/centre_x/centre_y
//   centre_x     : column of the window centre
//   centre_y     : row of the window centre
//   frame_done   : one-cycle pulse after the last pixel of a frame
// ----------------------------------------------------------------------------
module kernel_window_gen #(
   parameter int unsigned IMG_W  = 640,
   parameter int unsigned IMG_H  = 480,
   parameter int unsigned DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        pixel_in,
   input  logic                     pixel_valid,
   output logic [DATA_W-1:0]        kernel [48:0],
   output logic                     kernel_valid,
   output logic [$clog2(IMG_W)-1:0] centre_x,
   output logic [$clog2(IMG_H)-1:0] centre_y,
   output logic                     frame_done
);

   localparam int unsigned K    = 7;
   localparam int unsigned N_LB = K - 1;
   localparam int unsigned HALF = K / 2;
   localparam int unsigned XW   = $clog2(IMG_W);
   localparam int unsigned YW   = $clog2(IMG_H);

   // Raster position of the pixel that will be accepted next
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [XW-1:0] x_d;
   logic [YW-1:0] y_d;

   logic          kv_d;
   logic          fd_d;
   logic [XW-1:0] cx_d;
   logic [YW-1:0] cy_d;
   logic          last_col;
   logic          last_row;
   logic          window_full;

   // Line-buffer storage: buffer k holds row y-1-k at column x
   logic [DATA_W-1:0] lb_mem [N_LB][IMG_W];
   logic [DATA_W-1:0] lb_rd  [N_LB];

   // Fresh column entering window column 6, index = window row
   logic [DATA_W-1:0] col    [K];

   // Line-buffer read port at the current column
   always_comb begin
      for (int k = 0; k < int'(N_LB); k++) begin
         lb_rd[k] = lb_mem[k][x_q];
      end
   end

   // New window column: oldest row (lb5) on top, incoming pixel at the bottom
   always_comb begin
      for (int r = 0; r < int'(K); r++) begin
         col[r] = '0;
      end
      for (int r = 0; r < int'(N_LB); r++) begin
         col[r] = lb_rd[int'(N_LB) - 1 - r];
      end
      col[K-1] = pixel_in;
   end

   // Next-state and output decode for the raster counters
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      kv_d        = 1'b0;
      fd_d        = 1'b0;
      cx_d        = centre_x;
      cy_d        = centre_y;
      last_col    = (x_q == XW'(IMG_W - 1));
      last_row    = (y_q == YW'(IMG_H - 1));
      // Left/top six columns/rows hold wrapped or previous-frame data
      window_full = (x_q >= XW'(K - 1)) && (y_q >= YW'(K - 1));

      if (pixel_valid) begin
         if (last_col) begin
            x_d = '0;
            y_d = last_row ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end

         if (window_full) begin
            kv_d = 1'b1;
            cx_d = x_q - XW'(HALF);
            cy_d = y_q - YW'(HALF);
         end

         fd_d = last_col && last_row;
      end
   end

   // Counter and qualifier registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q          <= '0;
         y_q          <= '0;
         kernel_valid <= 1'b0;
         frame_done   <= 1'b0;
         centre_x     <= '0;
         centre_y     <= '0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         kernel_valid <= kv_d;
         frame_done   <= fd_d;
         centre_x     <= cx_d;
         centre_y     <= cy_d;
      end
   end

   // Line buffers: read old column this cycle, write it one buffer deeper
   always_ff @(posedge clk) begin
      if (pixel_valid) begin
         lb_mem[0][x_q] <= pixel_in;
         for (int k = 1; k < int'(N_LB); k++) begin
            lb_mem[k][x_q] <= lb_rd[k-1];
         end
      end
   end

   // 7x7 window: columns shift left, fresh column lands in column 6
   always_ff @(posedge clk) begin
      if (pixel_valid) begin
         for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K) - 1; c++) begin
               kernel[r*int'(K) + c] <= kernel[r*int'(K) + c + 1];
            end
            kernel[r*int'(K) + int'(K) - 1] <= col[r];
         end
      end
   end

endmodule

// File: tb/tb_kernel_window_gen.sv
// ----------------------------------------------------------------------------
// tb_kernel_window_gen
//   Three instances (8x8, 7x7, 11x9) driven from per-instance stimulus queues.
//   A frame-image reference model predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_kernel_window_gen;

   localparam int NI = 3;

   typedef struct packed {
      logic        rst;
      logic        v;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      int          cx;
      int          cy;
      logic [31:0] k0;
      logic [31:0] k24;
      logic [31:0] k48;
      logic        fd;
      logic        mixed;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pin [NI];
   logic        pv  [NI];

   logic [31:0] k0 [48:0];
   logic [31:0] k1 [48:0];
   logic [31:0] k2 [48:0];
   logic        kv0, kv1, kv2, fd0, fd1, fd2;
   logic [2:0]  cx0, cy0, cx1, cy1;
   logic [3:0]  cx2, cy2;

   always #5 clk = ~clk;

   kernel_window_gen #(.IMG_W(8), .IMG_H(8), .DATA_W(32)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .pixel_in(pin[0]), .pixel_valid(pv[0]),
      .kernel(k0), .kernel_valid(kv0), .centre_x(cx0), .centre_y(cy0),
      .frame_done(fd0));

   kernel_window_gen #(.IMG_W(7), .IMG_H(7), .DATA_W(32)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pixel_in(pin[1]), .pixel_valid(pv[1]),
      .kernel(k1), .kernel_valid(kv1), .centre_x(cx1), .centre_y(cy1),
      .frame_done(fd1));

   kernel_window_gen #(.IMG_W(11), .IMG_H(9), .DATA_W(32)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .pixel_in(pin[2]), .pixel_valid(pv[2]),
      .kernel(k2), .kernel_valid(kv2), .centre_x(cx2), .centre_y(cy2),
      .frame_done(fd2));

   int n_checks = 0;
   int n_pass   = 0;

   ent_t        src_q [NI][$];
   rec_t        rec0  [$];
   logic [31:0] k1_last [49];
   int          pulses [NI];

   // Reference model: the whole current frame as a 2-D image
   logic [31:0] img [NI][16][16];
   int          mx  [NI];
   int          my  [NI];
   logic        ekv [NI];
   logic        efd [NI];
   int          ecx [NI];
   int          ecy [NI];
   logic [31:0] ek  [NI][49];

   function automatic int img_w(input int i);
      case (i)
         0:       return 8;
         1:       return 7;
         default: return 11;
      endcase
   endfunction

   function automatic int img_h(input int i);
      case (i)
         0:       return 8;
         1:       return 7;
         default: return 9;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input int i, input logic r, input logic v, input logic [31:0] d);
      ent_t e;
      e.rst = r;
      e.v   = v;
      e.d   = d;
      src_q[i].push_back(e);
   endtask

   task automatic push_frame(input int i, input logic [31:0] base, input bit bubbles);
      for (int y = 0; y < img_h(i); y++) begin
         for (int x = 0; x < img_w(i); x++) begin
            push(i, 1'b0, 1'b1, base + 32'(y*img_w(i) + x));
            if (bubbles) push(i, 1'b0, 1'b0, 32'hDEAD_BEEF);
         end
      end
   endtask

   task automatic push_rand_frame(input int i);
      for (int p = 0; p < img_w(i)*img_h(i); p++) begin
         if ($urandom_range(0, 3) == 0) push(i, 1'b0, 1'b0, $urandom);
         push(i, 1'b0, 1'b1, $urandom);
      end
   endtask

   task automatic model_clk();
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            mx[i] = 0; my[i] = 0; ekv[i] = 1'b0; efd[i] = 1'b0;
            ecx[i] = 0; ecy[i] = 0;
         end else if (pv[i]) begin
            img[i][my[i]][mx[i]] = pin[i];
            ekv[i] = (mx[i] >= 6) && (my[i] >= 6);
            efd[i] = (mx[i] == img_w(i) - 1) && (my[i] == img_h(i) - 1);
            if (ekv[i]) begin
               ecx[i] = mx[i] - 3;
               ecy[i] = my[i] - 3;
               for (int r = 0; r < 7; r++)
                  for (int c = 0; c < 7; c++)
                     ek[i][r*7 + c] = img[i][my[i] - 6 + r][mx[i] - 6 + c];
            end
            mx[i]++;
            if (mx[i] == img_w(i)) begin
               mx[i] = 0;
               my[i]++;
               if (my[i] == img_h(i)) my[i] = 0;
            end
         end else begin
            ekv[i] = 1'b0;
            efd[i] = 1'b0;
         end
      end
   endtask

   task automatic chk_inst(input int i, input logic kv, input logic fd, input int cx,
                           input int cy, input logic [31:0] k [48:0]);
      check($sformatf("i%0d kernel_valid", i), 64'(kv), 64'(ekv[i]));
      check($sformatf("i%0d frame_done", i), 64'(fd), 64'(efd[i]));
      check($sformatf("i%0d centre_x", i), 64'(cx), 64'(ecx[i]));
      check($sformatf("i%0d centre_y", i), 64'(cy), 64'(ecy[i]));
      if (ekv[i]) begin
         for (int e = 0; e < 49; e++)
            check($sformatf("i%0d kernel[%0d] @(%0d,%0d)", i, e, ecx[i], ecy[i]),
                  64'(k[e]), 64'(ek[i][e]));
      end
      if (kv) pulses[i]++;
   endtask

   task automatic compare_all();
      rec_t r;
      logic lo, hi;
      chk_inst(0, kv0, fd0, int'(cx0), int'(cy0), k0);
      chk_inst(1, kv1, fd1, int'(cx1), int'(cy1), k1);
      chk_inst(2, kv2, fd2, int'(cx2), int'(cy2), k2);
      if (kv0) begin
         lo = 1'b0;
         hi = 1'b0;
         for (int e = 0; e < 49; e++) begin
            if (k0[e] < 32'd100) lo = 1'b1;
            else hi = 1'b1;
         end
         r.cx = int'(cx0); r.cy = int'(cy0);
         r.k0 = k0[0]; r.k24 = k0[24]; r.k48 = k0[48];
         r.fd = fd0; r.mixed = lo && hi;
         rec0.push_back(r);
      end
      if (kv1) for (int e = 0; e < 49; e++) k1_last[e] = k1[e];
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge
   task automatic step();
      ent_t e;
      for (int i = 0; i < NI; i++) begin
         if (src_q[i].size() > 0) e = src_q[i].pop_front();
         else e = '0;
         pv[i]  = e.v;
         pin[i] = e.d;
         if (i == 0) rst_n = ~e.rst;
      end
      @(posedge clk);
      model_clk();
      @(negedge clk);
      compare_all();
   endtask

   function automatic bit pending();
      return (src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0;
   endfunction

   task automatic drain();
      int guard = 0;
      while (pending() && guard < 5000) begin
         step();
         guard++;
      end
      check("drain within budget", 64'(pending()), 64'd0);
      step();
      step();
   endtask

   task automatic clear_stats();
      for (int i = 0; i < NI; i++) pulses[i] = 0;
      rec0.delete();
   endtask

   // Expected window pattern of one continuous 8x8 frame with pixel = y*8+x
   task automatic check_basic(input string tag);
      check({tag, " pulses"}, 64'(pulses[0]), 64'd4);
      if (rec0.size() > 0) begin
         check({tag, " first cx"}, 64'(rec0[0].cx), 64'd3);
         check({tag, " first cy"}, 64'(rec0[0].cy), 64'd3);
         check({tag, " first k0"}, 64'(rec0[0].k0), 64'd0);
         check({tag, " first k24"}, 64'(rec0[0].k24), 64'd27);
         check({tag, " first k48"}, 64'(rec0[0].k48), 64'd54);
         check({tag, " last cx"}, 64'(rec0[rec0.size()-1].cx), 64'd4);
         check({tag, " last cy"}, 64'(rec0[rec0.size()-1].cy), 64'd4);
         check({tag, " last k0"}, 64'(rec0[rec0.size()-1].k0), 64'd9);
         check({tag, " last k48"}, 64'(rec0[rec0.size()-1].k48), 64'd63);
         check({tag, " last fd"}, 64'(rec0[rec0.size()-1].fd), 64'd1);
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         pin[i] = '0; pv[i] = 1'b0; mx[i] = 0; my[i] = 0;
         ekv[i] = 1'b0; efd[i] = 1'b0; ecx[i] = 0; ecy[i] = 0; pulses[i] = 0;
      end

      // Reset
      for (int n = 0; n < 3; n++) push(0, 1'b1, 1'b0, 32'd0);
      drain();
      check("reset kernel_valid", 64'(kv0), 64'd0);
      check("reset centre_x", 64'(cx2), 64'd0);
      check("reset frame_done", 64'(fd1), 64'd0);

      // Basic 8x8, float passthrough 7x7, random 11x9
      clear_stats();
      push_frame(0, 32'd0, 1'b0);
      push_frame(1, 32'h3F80_0000, 1'b0);
      push_rand_frame(2);
      drain();
      check_basic("basic");
      check("float pulses", 64'(pulses[1]), 64'd1);
      check("float centre_x", 64'(cx1), 64'd3);
      check("float centre_y", 64'(cy1), 64'd3);
      for (int e = 0; e < 49; e++)
         check($sformatf("float kernel[%0d]", e), 64'(k1_last[e]), 64'(32'h3F80_0000 + 32'(e)));
      check("rand11x9 pulses", 64'(pulses[2]), 64'd15);

      // Bubbles
      clear_stats();
      push_frame(0, 32'd0, 1'b1);
      drain();
      check_basic("bubbles");

      // Two back-to-back frames
      clear_stats();
      push_frame(0, 32'd0, 1'b0);
      push_frame(0, 32'd100, 1'b0);
      drain();
      check("2frames pulses", 64'(pulses[0]), 64'd8);
      if (rec0.size() > 4) begin
         check("2frames fifth k0", 64'(rec0[4].k0), 64'd100);
         check("2frames fifth k48", 64'(rec0[4].k48), 64'd154);
      end
      for (int n = 0; n < rec0.size(); n++)
         check($sformatf("2frames window %0d unmixed", n), 64'(rec0[n].mixed), 64'd0);

      // Reset mid-frame after pixel 40, then a full frame
      for (int p = 0; p <= 40; p++) push(0, 1'b0, 1'b1, 32'(p));
      push(0, 1'b1, 1'b0, 32'd0);
      push(0, 1'b1, 1'b0, 32'd0);
      drain();
      clear_stats();
      push_frame(0, 32'd0, 1'b0);
      drain();
      check_basic("midreset");

      // Random data and bubbles, several frames on every instance
      clear_stats();
      for (int f = 0; f < 3; f++) push_rand_frame(0);
      for (int f = 0; f < 2; f++) push_rand_frame(1);
      for (int f = 0; f < 4; f++) push_rand_frame(2);
      drain();
      check("rand pulses i0", 64'(pulses[0]), 64'd12);
      check("rand pulses i1", 64'(pulses[1]), 64'd2);
      check("rand pulses i2", 64'(pulses[2]), 64'd60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
